// File: rtl/host_if_pkg.sv
// Shared definitions for the host memory responder: responder state encoding,
// cache-line width and the request address field layout.
package host_if_pkg;

  // Width of one cache line moved over the host data buses.
  localparam int LINE_BITS = 512;

  // Request addresses are word-granular; bit 2 is the line index LSB and
  // bits [1:0] must be zero.
  localparam int ADDR_IDX_LSB = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_WAIT,
    ST_WR_RESP,
    ST_GAP
  } resp_state_e;

  // Largest of three latency parameters; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/host_mem_responder_line_ram.sv
// Single-port synchronous line memory with write enable and registered read.
module line_ram #(
  parameter int AW = 10,
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Write when enabled; the read port registers the addressed line every cycle.
  // NOTE: the array has no reset; clearing 2^AW wide lines would prevent a
  // RAM macro from being inferred, and contents survive rst_n by design.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/host_mem_responder.sv
// Host-side responder: preloads a line memory, then serves MMU cache-line
// read/write requests after fixed latencies with a req/ready/ack handshake.
module host_mem_responder
  import host_if_pkg::*;
#(
  parameter int LINE_AW  = 10,
  parameter int RD_LAT   = 4,
  parameter int WR_LAT   = 4,
  parameter int INIT_DLY = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_en,
  input  logic [LINE_AW-1:0]   ld_addr,
  input  logic [LINE_BITS-1:0] ld_data,
  input  logic                 ld_done,
  input  logic [63:0]          cpu_addr,
  input  logic                 host_rgo,
  input  logic                 host_re,
  input  logic                 host_wgo,
  input  logic                 host_we,
  input  logic [LINE_BITS-1:0] host_data_bus_write_out,
  output logic                 host_init,
  output logic                 host_rd_ready,
  output logic                 host_wr_ready,
  output logic [LINE_BITS-1:0] host_data_bus_read_in,
  output logic                 addr_err
);

  localparam int CNT_MAX = max3(RD_LAT, WR_LAT, INIT_DLY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_DLY);

  resp_state_e            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_last;      // counter expired; final pipeline cycle
  logic                   r_init_run;  // ld_done seen, init delay running
  logic [LINE_AW-1:0]     r_line;
  logic                   r_err;
  logic [LINE_BITS-1:0]   r_wdata;
  logic                   r_host_init;
  logic                   r_rd_ready;
  logic                   r_wr_ready;
  logic [LINE_BITS-1:0]   r_rdata;
  logic                   r_addr_err;

  logic                   w_req_err;
  logic [LINE_AW-1:0]     w_req_line;
  logic                   w_ram_we;
  logic [LINE_AW-1:0]     w_ram_addr;
  logic [LINE_BITS-1:0]   w_ram_wdata;
  logic [LINE_BITS-1:0]   w_ram_q;

  // Out-of-range index bits or a misaligned word address flag the request.
  assign w_req_err  = (|cpu_addr[63:LINE_AW+ADDR_IDX_LSB]) | (|cpu_addr[ADDR_IDX_LSB-1:0]);
  assign w_req_line = cpu_addr[LINE_AW+ADDR_IDX_LSB-1:ADDR_IDX_LSB];

  // Preload owns the RAM port in INIT; afterwards the latched request line does.
  // The host write commits on the WR_WAIT -> WR_RESP transition only.
  assign w_ram_we    = ((r_state == ST_INIT) && ld_en) ||
                       ((r_state == ST_WR_WAIT) && r_last && !r_err);
  assign w_ram_addr  = (r_state == ST_INIT) ? ld_addr : r_line;
  assign w_ram_wdata = (r_state == ST_INIT) ? ld_data : r_wdata;

  line_ram #(
    .AW (LINE_AW),
    .DW (LINE_BITS)
  ) u_line_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

  // Responder FSM with latency counter, error tracking and registered outputs.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_init_run  <= 1'b0;
      r_line      <= '0;
      r_err       <= 1'b0;
      r_wdata     <= '0;
      r_host_init <= 1'b0;
      r_rd_ready  <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rdata     <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_run) begin
            if (r_cnt == '0) begin
              r_init_run  <= 1'b0;
              r_host_init <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end else if (ld_done) begin
            r_init_run <= 1'b1;
            r_cnt      <= INIT_LOAD;
          end
        end

        ST_IDLE: begin
          r_last <= 1'b0;
          if (host_rgo || host_wgo) begin
            r_line     <= w_req_line;
            r_err      <= w_req_err;
            r_addr_err <= r_addr_err | w_req_err;
          end
          // Read has priority; a concurrent write stays pending on host_wgo.
          if (host_rgo) begin
            r_cnt   <= RD_LOAD;
            r_state <= ST_RD_WAIT;
          end else if (host_wgo) begin
            r_cnt   <= WR_LOAD;
            r_wdata <= host_data_bus_write_out;
            r_state <= ST_WR_WAIT;
          end
        end

        // The extra r_last cycle lets the registered RAM read settle.
        ST_RD_WAIT: begin
          if (r_last) begin
            r_rdata    <= r_err ? '0 : w_ram_q;
            r_rd_ready <= 1'b1;
            r_state    <= ST_RD_RESP;
          end else if (r_cnt == '0) begin
            r_last <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_RD_RESP: begin
          if (host_re) begin
            r_rd_ready <= 1'b0;
            r_state    <= ST_GAP;
          end
        end

        ST_WR_WAIT: begin
          if (r_last) begin
            r_wr_ready <= 1'b1;
            r_state    <= ST_WR_RESP;
          end else if (r_cnt == '0) begin
            r_last <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_WR_RESP: begin
          if (host_we) begin
            r_wr_ready <= 1'b0;
            r_state    <= ST_GAP;
          end
        end

        ST_GAP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign host_init             = r_host_init;
  assign host_rd_ready         = r_rd_ready;
  assign host_wr_ready         = r_wr_ready;
  assign host_data_bus_read_in = r_rdata;
  assign addr_err              = r_addr_err;

endmodule

// File: tb/tb_host_mem_responder.sv
// Self-checking bench for host_mem_responder: directed scenarios followed by
// randomized traffic against a line-level memory model.
module tb_host_mem_responder;

  localparam int LINE_AW  = 10;
  localparam int RD_LAT   = 4;
  localparam int WR_LAT   = 4;
  localparam int INIT_DLY = 8;
  localparam int TIMEOUT  = 200;
  localparam int NLINES   = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ld_en;
  logic [LINE_AW-1:0] ld_addr;
  logic [511:0]       ld_data;
  logic               ld_done;
  logic [63:0]        cpu_addr;
  logic               host_rgo;
  logic               host_re;
  logic               host_wgo;
  logic               host_we;
  logic [511:0]       host_data_bus_write_out;
  logic               host_init;
  logic               host_rd_ready;
  logic               host_wr_ready;
  logic [511:0]       host_data_bus_read_in;
  logic               addr_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: line contents for the lines the bench uses, plus the
  // expected sticky error flag.
  logic [511:0] model_mem [NLINES];
  logic         exp_err;

  host_mem_responder #(
    .LINE_AW  (LINE_AW),
    .RD_LAT   (RD_LAT),
    .WR_LAT   (WR_LAT),
    .INIT_DLY (INIT_DLY)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ld_en                   (ld_en),
    .ld_addr                 (ld_addr),
    .ld_data                 (ld_data),
    .ld_done                 (ld_done),
    .cpu_addr                (cpu_addr),
    .host_rgo                (host_rgo),
    .host_re                 (host_re),
    .host_wgo                (host_wgo),
    .host_we                 (host_we),
    .host_data_bus_write_out (host_data_bus_write_out),
    .host_init               (host_init),
    .host_rd_ready           (host_rd_ready),
    .host_wr_ready           (host_wr_ready),
    .host_data_bus_read_in   (host_data_bus_read_in),
    .addr_err                (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic addr_bad(input logic [63:0] a);
    return (a[63:LINE_AW+2] != '0) || (a[1:0] != 2'b00);
  endfunction

  function automatic int addr_line(input logic [63:0] a);
    return int'(a[LINE_AW+1:2]);
  endfunction

  // Raise ld_done and expect host_init INIT_DLY+1 edges after the sampling
  // edge; optionally pulse a read request that must be ignored.
  task automatic do_init(input logic pulse_rd);
    int  n;
    logic saw_ready;
    saw_ready = 1'b0;
    ld_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      saw_ready = saw_ready | host_rd_ready | host_wr_ready;
      if (pulse_rd && n == 2) begin
        cpu_addr = 64'h000C;
        host_rgo = 1'b1;
      end else begin
        host_rgo = 1'b0;
      end
    end while (!host_init && n < TIMEOUT);
    host_rgo = 1'b0;
    check("init_seen", host_init, 1'b1);
    check("init_latency", n - 1, INIT_DLY + 1);
    repeat (RD_LAT + 4) begin
      @(negedge clk);
      saw_ready = saw_ready | host_rd_ready | host_wr_ready;
    end
    check("init_no_response", saw_ready, 1'b0);
  endtask

  // One complete read; expects the DUT idle when called and leaves it idle.
  task automatic do_read(input logic [63:0] addr, input int ack_dly, input logic chk_lat);
    logic [511:0] exp;
    int n;
    exp     = addr_bad(addr) ? '0 : model_mem[addr_line(addr)];
    exp_err = exp_err | addr_bad(addr);
    cpu_addr = addr;
    host_rgo = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_rd_ready && n < TIMEOUT);
    check("rd_ready", host_rd_ready, 1'b1);
    if (chk_lat) check("rd_latency", n - 1, RD_LAT + 1);
    check("rd_data", host_data_bus_read_in, exp);
    check("rd_addr_err", addr_err, exp_err);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      check("rd_hold_ready", host_rd_ready, 1'b1);
      check("rd_hold_data", host_data_bus_read_in, exp);
    end
    host_re  = 1'b1;
    host_rgo = 1'b0;
    @(negedge clk);
    host_re = 1'b0;
    check("rd_gap_ready", host_rd_ready, 1'b0);
    @(negedge clk);
  endtask

  // One complete write; updates the model only for a well-formed address.
  task automatic do_write(input logic [63:0] addr, input logic [511:0] data, input int ack_dly);
    int n;
    exp_err = exp_err | addr_bad(addr);
    cpu_addr = addr;
    host_data_bus_write_out = data;
    host_wgo = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_wr_ready && n < TIMEOUT);
    host_data_bus_write_out = rand_line();
    check("wr_ready", host_wr_ready, 1'b1);
    check("wr_latency", n - 1, WR_LAT + 1);
    check("wr_addr_err", addr_err, exp_err);
    repeat (ack_dly) @(negedge clk);
    check("wr_ready_held", host_wr_ready, 1'b1);
    host_we  = 1'b1;
    host_wgo = 1'b0;
    @(negedge clk);
    host_we = 1'b0;
    check("wr_gap_ready", host_wr_ready, 1'b0);
    @(negedge clk);
    if (!addr_bad(addr)) model_mem[addr_line(addr)] = data;
  endtask

  initial begin
    logic [511:0] d;
    logic [63:0]  a;
    int           n;
    int           ln;

    rst_n = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    cpu_addr = '0; host_rgo = 1'b0; host_re = 1'b0;
    host_wgo = 1'b0; host_we = 1'b0; host_data_bus_write_out = '0;
    exp_err = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_host_init", host_init, 1'b0);
    check("rst_rd_ready", host_rd_ready, 1'b0);
    check("rst_wr_ready", host_wr_ready, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_rd_data", host_data_bus_read_in, '0);
    rst_n = 1'b1;

    // Preload lines 0..7, line 3 = A5 pattern
    for (int i = 0; i < NLINES; i++) begin
      model_mem[i] = (i == 3) ? {64{8'hA5}} : rand_line();
      ld_en = 1'b1; ld_addr = LINE_AW'(i); ld_data = model_mem[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
    @(negedge clk);
    check("pre_done_init", host_init, 1'b0);
    do_init(1'b1);

    // Basic read of line 3 and write/read of line 4
    do_read(64'h000C, 0, 1'b1);
    do_write(64'h0010, 512'h1234, 0);
    do_read(64'h0010, 0, 1'b1);

    // Preload strobe outside INIT must not touch memory
    ld_en = 1'b1; ld_addr = LINE_AW'(5); ld_data = rand_line();
    @(negedge clk);
    ld_en = 1'b0;
    @(negedge clk);
    do_read(64'h0014, 1, 1'b1);

    // Simultaneous read and write to line 6: read first, write after GAP
    d = rand_line();
    cpu_addr = 64'h0018; host_data_bus_write_out = d;
    host_rgo = 1'b1; host_wgo = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!host_rd_ready && n < TIMEOUT);
    check("sim_rd_ready", host_rd_ready, 1'b1);
    check("sim_rd_data_old", host_data_bus_read_in, model_mem[6]);
    check("sim_no_wr_ready", host_wr_ready, 1'b0);
    host_re = 1'b1; host_rgo = 1'b0;
    @(negedge clk);
    host_re = 1'b0;
    check("sim_gap_rd", host_rd_ready, 1'b0);
    check("sim_gap_wr", host_wr_ready, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!host_wr_ready && n < TIMEOUT);
    check("sim_wr_ready", host_wr_ready, 1'b1);
    host_we = 1'b1; host_wgo = 1'b0;
    @(negedge clk);
    host_we = 1'b0;
    check("sim_wr_gap", host_wr_ready, 1'b0);
    @(negedge clk);
    model_mem[6] = d;
    do_read(64'h0018, 0, 1'b1);

    // Withheld acknowledge: ready and data stay stable for 20 cycles
    do_read(64'h0004, 20, 1'b1);
    check("init_sticky", host_init, 1'b1);

    // Address errors: high bits, then misaligned write; flag is sticky
    do_read(64'h1_0000_0000, 0, 1'b1);
    do_write(64'h0000_0000_0000_0012, rand_line(), 0);
    do_read(64'h0010, 0, 1'b1);

    // Randomized traffic over lines 0..7
    for (int t = 0; t < 40; t++) begin
      ln = $urandom_range(NLINES - 1);
      a  = 64'(ln) << 2;
      if ($urandom_range(7) == 0) begin
        if ($urandom_range(1) == 0) a[1:0] = 2'($urandom_range(3, 1));
        else a[$urandom_range(63, LINE_AW + 2)] = 1'b1;
      end
      if ($urandom_range(1) == 0) do_read(a, $urandom_range(3), 1'b1);
      else do_write(a, rand_line(), $urandom_range(3));
    end

    // Reset during WR_WAIT: outputs clear at once, write is not committed
    do_read(64'h000C, 0, 1'b1);
    cpu_addr = 64'h0010; host_data_bus_write_out = rand_line(); host_wgo = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0; ld_done = 1'b0;
    #1;
    check("arst_host_init", host_init, 1'b0);
    check("arst_rd_ready", host_rd_ready, 1'b0);
    check("arst_wr_ready", host_wr_ready, 1'b0);
    check("arst_addr_err", addr_err, 1'b0);
    check("arst_rd_data", host_data_bus_read_in, '0);
    host_wgo = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_init", host_init, 1'b0);
    do_init(1'b0);
    do_read(64'h0010, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute backstop in case a handshake loop is ever bypassed.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/host_mem_responder.md
# host_mem_responder

Host-side responder for the MMU's cache-line host interface. Accepts read (`host_rgo`) and write (`host_wgo`) requests, serves them from an internal 512-bit line memory after a configurable latency, and drives `host_rd_ready`, `host_wr_ready` and `host_data_bus_read_in`. It also asserts `host_init` once preloading is done. It stands in for the FPGA host shell in simulation and standalone FPGA builds.

## Interface
- `LINE_AW`, 10: line-address width; memory depth is 2^LINE_AW lines of 512 bits.
- `RD_LAT`, 4: cycles from read acceptance to `host_rd_ready`; must be ≥1.
- `WR_LAT`, 4: cycles from write acceptance to `host_wr_ready`; must be ≥1.
- `INIT_DLY`, 8: cycles after `ld_done` before `host_init` is asserted.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `ld_en`  in  1  preload write strobe; honoured only in INIT.
- `ld_addr`  in  LINE_AW  preload line index.
- `ld_data`  in  512  preload line data.
- `ld_done`  in  1  preload complete; level, sampled in INIT.
- `cpu_addr`  in  64  request address; line index = `cpu_addr[LINE_AW+1:2]`.
- `host_rgo`  in  1  read request, held until acknowledged.
- `host_re`  in  1  read acknowledge, sampled while `host_rd_ready` is high.
- `host_wgo`  in  1  write request, held until acknowledged.
- `host_we`  in  1  write acknowledge, sampled while `host_wr_ready` is high.
- `host_data_bus_write_out`  in  512  write data; captured at acceptance.
- `host_init`  out  1  host ready; sticky once set.
- `host_rd_ready`  out  1  read data valid.
- `host_wr_ready`  out  1  write complete.
- `host_data_bus_read_in`  out  512  read line data.
- `addr_err`  out  1  sticky flag: a request had nonzero `cpu_addr[63:LINE_AW+2]` or nonzero `cpu_addr[1:0]`.

## Operation
- States: INIT, IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP, GAP.
- **INIT**
  - `ld_en` writes `ld_data` to `mem[ld_addr]`.
  - When `ld_done` is seen high, a counter runs INIT_DLY cycles, then the FSM moves to IDLE and `host_init` goes to 1.
  - Requests in INIT are ignored.
- **IDLE**
  - Accept a request: latch the line index and start the latency counter.
  - `host_rgo` → RD_WAIT. `host_wgo` → WR_WAIT; write data is captured.
  - If both are high in the same cycle, the read wins and the write stays pending.
- **Address errors**
  - An out-of-range request sets `addr_err`.
  - An errored read returns all-zero data. An errored write completes its handshake but does not modify memory.
- **RD_WAIT**
  - The counter counts down from RD_LAT-1.
  - At 0, the memory word is registered onto `host_data_bus_read_in` and the FSM moves to RD_RESP.
- **RD_RESP**
  - `host_rd_ready`=1 and the data is held stable.
  - When `host_re`=1 in the same cycle → GAP.
  - If `host_re` stays 0, hold indefinitely.
- **WR_WAIT**: counts WR_LAT-1 down to 0 → WR_RESP; memory is written on that transition.
- **WR_RESP**: `host_wr_ready`=1 until `host_we`=1 → GAP.
- **GAP**
  - One idle cycle with no ready asserted, then IDLE.
  - A request that dropped during the wait or response is not cancelled; the response completes normally.
- `host_rgo` or `host_wgo` deasserting in any state other than IDLE is ignored.

## Timing
- Reset values:
  - FSM = INIT.
  - `host_init`, `host_rd_ready`, `host_wr_ready`, `addr_err` = 0.
  - `host_data_bus_read_in` = 0.
  - Memory contents are not reset.
- An asynchronous reset mid-transaction aborts it immediately. A write that has not reached WR_RESP is not committed.
- Read latency: request seen in IDLE at cycle t → `host_rd_ready` high at t+RD_LAT+1.
- Minimum back-to-back request spacing: acknowledge cycle, one GAP cycle, then IDLE accepts. The MMU's READY cycle aligns with GAP.
- All outputs are registered; acknowledges are sampled at the same clock edge.
- Counter width is ⌈log2(max(RD_LAT,WR_LAT,INIT_DLY)+1)⌉; no wrap is possible.
- Line index truncation is never silent: it always sets `addr_err`.

## Structure
- Shared package `host_if_pkg`:
  - responder state enum;
  - `LINE_BITS`=512;
  - address-field constants (index LSB = 2).
- One sub-module `line_ram`: single-port 2^LINE_AW×512 synchronous RAM with write enable and registered read. Writes are muxed between the preload and host ports; INIT exclusivity guarantees there is no conflict.
- The FSM, counter and error logic live in the top level.

## Test plan
- **Init:** preload line 3 = 512'hA5…, `ld_done` at cycle 10 → `host_init` rises at cycle 10+INIT_DLY+1; a `host_rgo` pulse during INIT gets no response.
- **Read:** `cpu_addr`=64'h000C, `host_rgo` held, `host_re` driven off `host_rd_ready` → ready after RD_LAT+1 cycles, data = line 3, one GAP cycle after the acknowledge.
- **Write then read:** `host_wgo` with `cpu_addr`=64'h0010 and data 512'h1234 → `host_wr_ready` after WR_LAT+1 cycles; a subsequent read of 64'h0010 returns 512'h1234.
- **Simultaneous:** `host_rgo` and `host_wgo` in the same IDLE cycle → read served first, then the write after GAP; final memory is correct.
- **Hold:** withhold `host_re` for 20 cycles → `host_rd_ready` and data stay stable; the acknowledge completes the transaction.
- **Error and reset:**
  - `cpu_addr`=64'h1_0000_0000 read → zeros returned, `addr_err`=1 and sticky.
  - Reset asserted during WR_WAIT → all outputs are 0 immediately; a later read of the target line shows the old data.
